// File: rtl/kronos_execute.sv
// Kronos RV32I execute stage: ALU/comparator result (result1), op3+op4 adder
// (result2), and the registered EX/WB packet with decode controls passed through.
// Shifts run iteratively, SHIFT_STEP bits per cycle, unless the optional
// single-cycle barrel shifter is enabled with `define KRONOS_EX_FAST_SHIFT_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// STEADY | idle or holding an output packet; may accept a new packet
// SHIFT  | iterative shift in progress; input stalled, output invalid
module kronos_execute #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        flush,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] op3,
  input  logic [31:0] op4,
  input  logic [3:0]  aluop,
  input  logic [4:0]  rd,
  input  logic        rd_write,
  input  logic        branch,
  input  logic        branch_cond,
  input  logic        ld,
  input  logic        st,
  input  logic        system,
  input  logic        is_illegal,
  input  logic [2:0]  funct3,
  output logic        pipe_out_vld,
  input  logic        pipe_out_rdy,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_write,
  output logic        ex_branch,
  output logic        ex_branch_cond,
  output logic        ex_ld,
  output logic        ex_st,
  output logic        ex_system,
  output logic [2:0]  ex_funct3,
  output logic        ex_is_illegal
);

  localparam logic [0:0] STEADY = 1'b0;
  localparam logic [0:0] SHIFT  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_NE   = 4'd11;
  localparam logic [3:0] OP_GE   = 4'd12;
  localparam logic [3:0] OP_GEU  = 4'd13;

  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

`ifdef KRONOS_EX_FAST_SHIFT_EN
  localparam logic ITER_SHIFT = 1'b0;
`else
  localparam logic ITER_SHIFT = 1'b1;
`endif

  logic [0:0]  state;
  logic [31:0] alu_out;
  logic [31:0] shreg;
  logic [31:0] shnext;
  logic [4:0]  remaining;
  logic [4:0]  step;
  logic [1:0]  sh_op;
  logic        accept;
  logic        is_shift_op;
  logic        go_shift;
  logic        last_step;

  assign pipe_in_rdy = (state == STEADY) & (~pipe_out_vld | pipe_out_rdy);
  assign accept      = pipe_in_vld & pipe_in_rdy;
  assign is_shift_op = (aluop == OP_SLL) | (aluop == OP_SRL) | (aluop == OP_SRA);
  // Zero-amount and illegal shifts take the single-cycle path.
  assign go_shift    = ITER_SHIFT & is_shift_op & ~is_illegal & (op2[4:0] != 5'd0);

  // Single-cycle ALU/comparator; iterative-mode shifts pass op1 (shamt=0 case).
  always_comb begin
    alu_out = op1;
    case (aluop)
      OP_ADD:  alu_out = op1 + op2;
      OP_SUB:  alu_out = op1 - op2;
      OP_AND:  alu_out = op1 & op2;
      OP_OR:   alu_out = op1 | op2;
      OP_XOR:  alu_out = op1 ^ op2;
      OP_SLT:  alu_out = {31'b0, $signed(op1) < $signed(op2)};
      OP_SLTU: alu_out = {31'b0, op1 < op2};
`ifdef KRONOS_EX_FAST_SHIFT_EN
      OP_SLL:  alu_out = op1 << op2[4:0];
      OP_SRL:  alu_out = op1 >> op2[4:0];
      OP_SRA:  alu_out = 32'($signed(op1) >>> op2[4:0]);
`endif
      OP_EQ:   alu_out = {31'b0, op1 == op2};
      OP_NE:   alu_out = {31'b0, op1 != op2};
      OP_GE:   alu_out = {31'b0, $signed(op1) >= $signed(op2)};
      OP_GEU:  alu_out = {31'b0, op1 >= op2};
      default: alu_out = op1;
    endcase
  end

  // One shift step: min(STEP, remaining) bits; SRA keeps replicating the sign.
  always_comb begin
    step      = (remaining < STEP) ? remaining : STEP;
    last_step = (remaining <= STEP);
    case (sh_op)
      SH_LL:   shnext = shreg << step;
      SH_RL:   shnext = shreg >> step;
      default: shnext = 32'($signed(shreg) >>> step);
    endcase
  end

  // Pipeline register and shift FSM; flush outranks accept, completion and hold.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state          <= STEADY;
      shreg          <= 32'd0;
      remaining      <= 5'd0;
      sh_op          <= SH_LL;
      pipe_out_vld   <= 1'b0;
      result1        <= 32'd0;
      result2        <= 32'd0;
      ex_rd          <= 5'd0;
      ex_rd_write    <= 1'b0;
      ex_branch      <= 1'b0;
      ex_branch_cond <= 1'b0;
      ex_ld          <= 1'b0;
      ex_st          <= 1'b0;
      ex_system      <= 1'b0;
      ex_funct3      <= 3'd0;
      ex_is_illegal  <= 1'b0;
    end else if (flush) begin
      state        <= STEADY;
      pipe_out_vld <= 1'b0;
    end else if (state == SHIFT) begin
      shreg     <= shnext;
      remaining <= remaining - step;
      if (last_step) begin
        result1      <= shnext;
        pipe_out_vld <= 1'b1;
        state        <= STEADY;
      end
    end else if (accept) begin
      result2        <= op3 + op4;
      ex_rd          <= rd;
      ex_rd_write    <= rd_write;
      ex_branch      <= branch;
      ex_branch_cond <= branch_cond;
      ex_ld          <= ld;
      ex_st          <= st;
      ex_system      <= system;
      ex_funct3      <= funct3;
      ex_is_illegal  <= is_illegal;
      if (go_shift) begin
        state        <= SHIFT;
        shreg        <= op1;
        remaining    <= op2[4:0];
        sh_op        <= (aluop == OP_SLL) ? SH_LL : (aluop == OP_SRL) ? SH_RL : SH_RA;
        pipe_out_vld <= 1'b0;
      end else begin
        result1      <= alu_out;
        pipe_out_vld <= 1'b1;
      end
    end else if (pipe_out_rdy) begin
      pipe_out_vld <= 1'b0;
    end
  end

endmodule
